apb_timer: RTL and testbench

APB_TIMER -- requirements
Module: apb_timer

---
 rtl/apb_timer.sv | 234 +++++++++++++++++++++++
 tb/tb_apb_timer.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer.sv
// ---------------------------------------------------------------------------
// apb_timer: zero-wait-state APB down-counting timer with interrupt.
//
// Register map (selected by PADDR[3:2], PADDR[1:0] ignored, anything with
// PADDR[ADDR_WIDTH-1:4] != 0 reads as zero and ignores writes):
//   0x0 CTRL   : bit0 EN, bit1 PERIODIC, bit2 IE, bits[15:8] PRESCALE
//   0x4 LOAD   : reload value, RW (a write also loads VALUE)
//   0x8 VALUE  : current count, RO
//   0xC STATUS : bit0 FLAG, write-1-to-clear
//
// Build option:
//   APB_TIMER_PRESCALER_EN - when defined, CTRL[15:8] holds PRESCALE and an
//   8-bit prescaler (PCNT) divides the tick rate by PRESCALE+1. When
//   undefined, the timer ticks on every enabled cycle, CTRL[15:8] is RAZ/WI
//   and no prescaler flops are built.
//
// Ports:
//   HCLK     - clock, shared with the AHB-to-APB bridge
//   HRESETn  - asynchronous active-low reset
//   PSEL     - slave select
//   PENABLE  - access phase
//   PADDR    - byte address
//   PWRITE   - 1 = write, 0 = read
//   PWDATA   - write data
//   PRDATA   - registered read data, captured on the read setup edge
//   IRQ      - registered level interrupt, FLAG && IE delayed by one cycle
// ---------------------------------------------------------------------------
module apb_timer #(
  parameter int unsigned ADDR_WIDTH = 32,
  // Only 32 is supported.
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  IRQ
);

  // Register offsets as decoded from PADDR[3:2].
  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegLoad   = 2'd1;
  localparam logic [1:0] RegValue  = 2'd2;
  localparam logic [1:0] RegStatus = 2'd3;

  localparam logic [DATA_WIDTH-1:0] One = DATA_WIDTH'(1);

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic       addr_hit;
  logic [1:0] reg_sel;
  logic       wr_access;
  logic       rd_setup;
  logic       wr_ctrl;
  logic       wr_load;
  logic       wr_status;

  assign addr_hit  = (PADDR[ADDR_WIDTH-1:4] == '0);
  assign reg_sel   = PADDR[3:2];
  assign wr_access = PSEL & PENABLE & PWRITE & addr_hit;
  // Reads are captured on the setup edge so PRDATA is stable for the whole
  // access phase; out-of-range reads still capture (as zero).
  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;

  assign wr_ctrl   = wr_access & (reg_sel == RegCtrl);
  assign wr_load   = wr_access & (reg_sel == RegLoad);
  assign wr_status = wr_access & (reg_sel == RegStatus);

  // PADDR[1:0] and the reserved PWDATA bits are intentionally ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{PADDR[1:0], PWDATA};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                  en_q, en_d;
  logic                  periodic_q, periodic_d;
  logic                  ie_q, ie_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  flag_q, flag_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  irq_q, irq_d;

  logic                  tick;
  logic                  expire;
  logic [7:0]            prescale_rd;

  // -------------------------------------------------------------------------
  // Tick generation
  // -------------------------------------------------------------------------
`ifdef APB_TIMER_PRESCALER_EN
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] pcnt_q, pcnt_d;

  assign tick        = en_q & (pcnt_q == prescale_q);
  assign prescale_rd = prescale_q;

  always_comb begin
    prescale_d = prescale_q;
    if (wr_ctrl) begin
      prescale_d = PWDATA[15:8];
    end
  end

  // Restarting the prescaler on any CTRL write makes the first tick after a
  // (re)configuration land exactly PRESCALE+1 cycles later.
  always_comb begin
    pcnt_d = pcnt_q + 8'd1;
    if (!en_q || wr_ctrl || tick) begin
      pcnt_d = 8'd0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prescale_q <= 8'd0;
      pcnt_q     <= 8'd0;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end
`else
  assign tick        = en_q;
  assign prescale_rd = 8'd0;
`endif

  // A tick with the counter already at zero is the expiry event.
  assign expire = tick & (value_q == '0);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    ie_d       = ie_q;
    // CTRL write takes priority over the one-shot self-disable.
    if (wr_ctrl) begin
      en_d       = PWDATA[0];
      periodic_d = PWDATA[1];
      ie_d       = PWDATA[2];
    end else if (expire && !periodic_q) begin
      en_d = 1'b0;
    end
  end

  always_comb begin
    load_d = load_q;
    if (wr_load) begin
      load_d = PWDATA;
    end
  end

  // A LOAD write overrides whatever the tick would have done to VALUE.
  always_comb begin
    value_d = value_q;
    if (wr_load) begin
      value_d = PWDATA;
    end else if (tick) begin
      if (value_q != '0) begin
        value_d = value_q - One;
      end else if (periodic_q) begin
        value_d = load_q;
      end else begin
        value_d = '0;
      end
    end
  end

  // Set beats W1C so an expiry is never lost to a racing clear.
  always_comb begin
    flag_d = flag_q;
    if (expire) begin
      flag_d = 1'b1;
    end else if (wr_status && PWDATA[0]) begin
      flag_d = 1'b0;
    end
  end

  always_comb begin
    prdata_d = prdata_q;
    if (rd_setup) begin
      prdata_d = '0;
      if (addr_hit) begin
        unique case (reg_sel)
          RegCtrl:   prdata_d = {{(DATA_WIDTH-16){1'b0}}, prescale_rd, 5'b0,
                                 ie_q, periodic_q, en_q};
          RegLoad:   prdata_d = load_q;
          RegValue:  prdata_d = value_q;
          RegStatus: prdata_d = {{(DATA_WIDTH-1){1'b0}}, flag_q};
          default:   prdata_d = '0;
        endcase
      end
    end
  end

  assign irq_d = flag_q & ie_q;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      load_q     <= '0;
      value_q    <= '0;
      flag_q     <= 1'b0;
      prdata_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      ie_q       <= ie_d;
      load_q     <= load_d;
      value_q    <= value_d;
      flag_q     <= flag_d;
      prdata_q   <= prdata_d;
      irq_q      <= irq_d;
    end
  end

  assign PRDATA = prdata_q;
  assign IRQ    = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// ---------------------------------------------------------------------------
// tb_apb_timer: directed self-checking bench for apb_timer.
// All inputs change 1 time unit after a rising edge; outputs are sampled at
// the same offset, i.e. away from the active edge.
// ---------------------------------------------------------------------------
module tb_apb_timer;

  logic        HCLK;
  logic        HRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        IRQ;

  int n_checks;
  int n_fail;
  logic [31:0] rd;

  apb_timer #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .IRQ    (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Watchdog: all waits are fixed cycle counts, this only guards the harness.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  // ---- bus helpers (called at posedge+1, return at posedge+1) -------------
  task automatic do_reset();
    HRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
  endtask

  // Commit happens on the second edge; returns 1 unit after it.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Captures register state as it stood when the task was called.
  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    d = PRDATA;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Holding the setup phase makes PRDATA sample the register every edge,
  // giving a cycle-by-cycle view of a register one edge late.
  task automatic stream(input logic [31:0] a);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
  endtask

  // ---- tests --------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] addrs [4];
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    n_checks++;
    if (PRDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_prdata: got %h expected %h", PRDATA, 32'h0);
    end
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b expected 0", IRQ);
    end
    for (int i = 0; i < 4; i++) begin
      apb_read(addrs[i], rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++; $display("FAIL reset_reg[%h]: got %h expected %h", addrs[i], rd, 32'h0);
      end
    end
  endtask

  task automatic test_periodic();
    logic [31:0] exp [7];
    exp = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd5};
    do_reset();
    apb_write(32'h4, 32'd5);
    apb_write(32'h0, 32'h3);
    stream(32'h8);
    for (int i = 0; i < 7; i++) begin
      @(posedge HCLK); #1;
      n_checks++;
      if (PRDATA !== exp[i]) begin
        n_fail++; $display("FAIL periodic_value[%0d]: got %h expected %h", i, PRDATA, exp[i]);
      end
    end
    stream(32'hC);
    @(posedge HCLK); #1;
    n_checks++;
    if (PRDATA !== 32'h1) begin
      n_fail++; $display("FAIL periodic_flag: got %h expected %h", PRDATA, 32'h1);
    end
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++; $display("FAIL periodic_irq_masked: got %b expected 0", IRQ);
    end
    PSEL = 1'b0;
    apb_write(32'h0, 32'h0);
  endtask

  task automatic test_oneshot();
    logic [31:0] exp [3];
    exp = '{32'd2, 32'd1, 32'd0};
    do_reset();
    apb_write(32'h4, 32'd2);
    apb_write(32'h0, 32'h1);
    stream(32'h8);
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #1;
      n_checks++;
      if (PRDATA !== exp[i]) begin
        n_fail++; $display("FAIL oneshot_value[%0d]: got %h expected %h", i, PRDATA, exp[i]);
      end
    end
    stream(32'hC);
    @(posedge HCLK); #1;
    n_checks++;
    if (PRDATA !== 32'h1) begin
      n_fail++; $display("FAIL oneshot_flag: got %h expected %h", PRDATA, 32'h1);
    end
    stream(32'h0);
    @(posedge HCLK); #1;
    n_checks++;
    if (PRDATA !== 32'h0) begin
      n_fail++; $display("FAIL oneshot_en_cleared: got %h expected %h", PRDATA, 32'h0);
    end
    stream(32'h8);
    for (int i = 0; i < 20; i++) begin
      @(posedge HCLK); #1;
      n_checks++;
      if (PRDATA !== 32'h0) begin
        n_fail++; $display("FAIL oneshot_hold[%0d]: got %h expected %h", i, PRDATA, 32'h0);
      end
    end
    PSEL = 1'b0;
  endtask

`ifdef APB_TIMER_PRESCALER_EN
  task automatic test_prescale();
    logic [31:0] exp [7];
    exp = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0};
    do_reset();
    apb_write(32'h4, 32'd1);
    apb_write(32'h0, 32'h0301);
    stream(32'h8);
    for (int i = 0; i < 7; i++) begin
      @(posedge HCLK); #1;
      n_checks++;
      if (PRDATA !== exp[i]) begin
        n_fail++; $display("FAIL prescale_value[%0d]: got %h expected %h", i, PRDATA, exp[i]);
      end
    end
    stream(32'hC);
    @(posedge HCLK); #1;
    n_checks++;
    if (PRDATA !== 32'h0) begin
      n_fail++; $display("FAIL prescale_flag_early: got %h expected %h", PRDATA, 32'h0);
    end
    @(posedge HCLK); #1;
    n_checks++;
    if (PRDATA !== 32'h1) begin
      n_fail++; $display("FAIL prescale_flag_at_8: got %h expected %h", PRDATA, 32'h1);
    end
    PSEL = 1'b0;
  endtask
`else
  task automatic test_no_prescale();
    logic [31:0] exp [4];
    exp = '{32'd3, 32'd2, 32'd1, 32'd0};
    do_reset();
    apb_write(32'h4, 32'd3);
    apb_write(32'h0, 32'h0301);
    stream(32'h8);
    for (int i = 0; i < 4; i++) begin
      @(posedge HCLK); #1;
      n_checks++;
      if (PRDATA !== exp[i]) begin
        n_fail++; $display("FAIL noprescale_value[%0d]: got %h expected %h", i, PRDATA, exp[i]);
      end
    end
    stream(32'hC);
    @(posedge HCLK); #1;
    n_checks++;
    if (PRDATA !== 32'h1) begin
      n_fail++; $display("FAIL noprescale_flag: got %h expected %h", PRDATA, 32'h1);
    end
    PSEL = 1'b0;
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL noprescale_ctrl_raz: got %h expected %h", rd, 32'h0);
    end
  endtask
`endif

  task automatic test_ctrl_fields();
    logic [31:0] exp_ctrl;
`ifdef APB_TIMER_PRESCALER_EN
    exp_ctrl = 32'h0000FF06;
`else
    exp_ctrl = 32'h00000006;
`endif
    do_reset();
    apb_write(32'h0, 32'hFFFFFF06);
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== exp_ctrl) begin
      n_fail++; $display("FAIL ctrl_fields: got %h expected %h", rd, exp_ctrl);
    end
  endtask

  task automatic test_irq();
    do_reset();
    apb_write(32'h4, 32'h0);
    apb_write(32'h0, 32'h1);  // one-shot from 0: FLAG sets on the next edge
    apb_write(32'h0, 32'h5);  // IE on with FLAG already set
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++; $display("FAIL irq_not_yet: got %b expected 0", IRQ);
    end
    @(posedge HCLK); #1;
    n_checks++;
    if (IRQ !== 1'b1) begin
      n_fail++; $display("FAIL irq_rise: got %b expected 1", IRQ);
    end
    apb_write(32'hC, 32'h1);  // timer is stopped, so no expiry races this
    n_checks++;
    if (IRQ !== 1'b1) begin
      n_fail++; $display("FAIL irq_lag_clear: got %b expected 1", IRQ);
    end
    @(posedge HCLK); #1;
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++; $display("FAIL irq_fall: got %b expected 0", IRQ);
    end
    apb_read(32'hC, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL w1c_flag: got %h expected %h", rd, 32'h0);
    end
    // LOAD=0 periodic expires every cycle, so any W1C coincides with a set.
    apb_write(32'h0, 32'h7);
    apb_write(32'hC, 32'h1);
    apb_read(32'hC, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL w1c_vs_set: got %h expected %h", rd, 32'h1);
    end
    n_checks++;
    if (IRQ !== 1'b1) begin
      n_fail++; $display("FAIL irq_periodic: got %b expected 1", IRQ);
    end
    apb_write(32'h0, 32'h0);
    apb_write(32'hC, 32'h1);
    apb_read(32'hC, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL w1c_after_stop: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_load_vs_tick();
    do_reset();
    apb_write(32'h4, 32'd10);
    apb_write(32'h0, 32'h3);
    apb_write(32'h4, 32'h20);  // commits on a ticking edge
    stream(32'h8);
    @(posedge HCLK); #1;
    n_checks++;
    if (PRDATA !== 32'h20) begin
      n_fail++; $display("FAIL load_wins: got %h expected %h", PRDATA, 32'h20);
    end
    @(posedge HCLK); #1;
    n_checks++;
    if (PRDATA !== 32'h1F) begin
      n_fail++; $display("FAIL load_then_dec: got %h expected %h", PRDATA, 32'h1F);
    end
    PSEL = 1'b0;
    apb_write(32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    apb_write(32'h4, 32'd1);
    apb_write(32'h0, 32'h1);  // VALUE 1 -> 0 next edge, expiry the edge after
    apb_write(32'h0, 32'h5);  // commits on the expiry edge
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h5) begin
      n_fail++; $display("FAIL ctrl_vs_oneshot: got %h expected %h", rd, 32'h5);
    end
    // Still at zero and enabled, so the next tick self-disables.
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++; $display("FAIL oneshot_redisable: got %h expected %h", rd, 32'h4);
    end
  endtask

  task automatic test_addr_decode();
    do_reset();
    apb_write(32'h4, 32'hA5A50003);
    apb_write(32'h0, 32'h4);
    apb_write(32'h40, 32'hFFFFFFFF);
    apb_write(32'h44, 32'hFFFFFFFF);
    apb_write(32'h80000004, 32'hFFFFFFFF);
    apb_read(32'h40, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL oob_read_40: got %h expected %h", rd, 32'h0);
    end
    apb_read(32'h80000004, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL oob_read_hi: got %h expected %h", rd, 32'h0);
    end
    apb_read(32'h0, rd);
    n_checks++;
    if (rd !== 32'h4) begin
      n_fail++; $display("FAIL oob_ctrl_kept: got %h expected %h", rd, 32'h4);
    end
    apb_read(32'h4, rd);
    n_checks++;
    if (rd !== 32'hA5A50003) begin
      n_fail++; $display("FAIL oob_load_kept: got %h expected %h", rd, 32'hA5A50003);
    end
    apb_read(32'h8, rd);  // EN=0 keeps VALUE frozen
    n_checks++;
    if (rd !== 32'hA5A50003) begin
      n_fail++; $display("FAIL value_frozen: got %h expected %h", rd, 32'hA5A50003);
    end
    apb_read(32'h7, rd);  // byte offset bits ignored
    n_checks++;
    if (rd !== 32'hA5A50003) begin
      n_fail++; $display("FAIL byte_offset: got %h expected %h", rd, 32'hA5A50003);
    end
    apb_read(32'hC, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL oob_status_kept: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apb_write(32'h4, 32'h0);
    apb_write(32'h0, 32'h5);  // expires at once, FLAG=1, EN clears, IE stays
    apb_write(32'h4, 32'd7);
    apb_read(32'h8, rd);
    n_checks++;
    if (rd !== 32'd7 || IRQ !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_state: got value %h irq %b expected %h 1", rd, IRQ, 32'd7);
    end
    // Access phase of a LOAD write, reset lands before its commit edge.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h99;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #2;
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if (PRDATA !== 32'h0 || IRQ !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got prdata %h irq %b expected 0 0", PRDATA, IRQ);
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    apb_read(32'h8, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_value: got %h expected %h", rd, 32'h0);
    end
    apb_read(32'h4, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_load: got %h expected %h", rd, 32'h0);
    end
    apb_read(32'hC, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_flag: got %h expected %h", rd, 32'h0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    HRESETn  = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    #1;
    test_reset();
    test_periodic();
    test_oneshot();
`ifdef APB_TIMER_PRESCALER_EN
    test_prescale();
`else
    test_no_prescale();
`endif
    test_ctrl_fields();
    test_irq();
    test_load_vs_tick();
    test_back_to_back();
    test_addr_decode();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
